// File: rtl/alu_shift_if.sv
// Request/result handshake bundle for the iterative shift/rotate unit.
// The master side issues operations and consumes results; the slave side is the shifter.
interface alu_shift_if #(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [AW-1:0]    amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, opcode, a, amt, out_ready,
        input  in_ready, out_valid, out, carry, zero, err
    );

    modport slave (
        input  in_valid, opcode, a, amt, out_ready,
        output in_ready, out_valid, out, carry, zero, err
    );
endinterface

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit: moves up to STEP bit positions per cycle until the
// requested amount is consumed, then presents result and flags until taken.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a request; in_ready high, last result held
//   ST_SHIFT | shifting the working value, remaining amount counts down
//   ST_DONE  | out_valid high, result/flags frozen until out_ready
module alu_shift_seq #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_shift_if.slave  bus
);
    localparam int AW = $clog2(WIDTH);

    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;

    localparam logic [AW:0]   STEP_W  = (AW+1)'(STEP);
    localparam logic [AW:0]   WIDTH_W = (AW+1)'(WIDTH);
    localparam logic [AW-1:0] WIDTH_M = AW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] val_q;
    logic [3:0]       op_q;
    logic [AW-1:0]    rem_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             zero_q;
    logic             err_q;

    logic             accept;
    logic             in_legal;
    logic             go_shift;
    logic [AW:0]      k_ext;
    logic [AW:0]      wk;
    logic [AW-1:0]    k;
    logic [AW-1:0]    idx_l;
    logic [AW-1:0]    idx_r;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] step_res;
    logic             step_carry;
    logic             last_step;

    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out       = out_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign in_legal = (bus.opcode >= OP_SLL) && (bus.opcode <= OP_ROR);
    assign go_shift = in_legal && (bus.amt != '0);

    // Per-cycle shift distance k = min(STEP, remaining); the final step leaves rem at 0.
    always_comb begin
        k_ext      = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
        k          = k_ext[AW-1:0];
        wk         = WIDTH_W - k_ext;
        idx_l      = WIDTH_M - k;
        idx_r      = k - 1'b1;
        shl        = val_q << k;
        shr        = val_q >> k;
        sra        = $signed(val_q) >>> k;
        last_step  = (rem_q == k);
        step_res   = val_q;
        step_carry = 1'b0;
        case (op_q)
            OP_SLL: begin
                step_res   = shl;
                step_carry = val_q[idx_l];
            end
            OP_SRL: begin
                step_res   = shr;
                step_carry = val_q[idx_r];
            end
            OP_SRA: begin
                step_res   = sra;
                step_carry = val_q[idx_r];
            end
            OP_ROL: begin
                step_res   = shl | (val_q >> wk);
                step_carry = step_res[0];
            end
            OP_ROR: begin
                step_res   = shr | (val_q << wk);
                step_carry = step_res[WIDTH-1];
            end
            default: begin
                step_res   = val_q;
                step_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = go_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_step) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Result registers only change on the edge that enters ST_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        val_q <= bus.a;
                        op_q  <= bus.opcode;
                        rem_q <= bus.amt;
                        if (!in_legal) begin
                            out_q   <= '0;
                            carry_q <= 1'b0;
                            zero_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (bus.amt == '0) begin
                            out_q   <= bus.a;
                            carry_q <= 1'b0;
                            zero_q  <= (bus.a == '0);
                            err_q   <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    val_q <= step_res;
                    rem_q <= rem_q - k;
                    if (last_step) begin
                        out_q   <= step_res;
                        carry_q <= step_carry;
                        zero_q  <= (step_res == '0);
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
